ds_dac_multi_ch: RTL

//  Parametrised N-channel delta-sigma DAC core: 1st- or 2nd-order modulators, one per channel.

---
 rtl/ds_dac_multi_ch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ds_dac_multi_ch.sv
// N-channel 1st/2nd-order delta-sigma DAC core with clock-enable divider and one-deep sample buffer.
// Define DS_DITHER_EN to add LFSR dither (-2..+1) at the quantiser input.
module ds_dac_multi_ch #(
    parameter int unsigned CH        = 2,
    parameter int unsigned DW        = 16,
    parameter int unsigned DIV_RATIO = 100,
    parameter int unsigned ORDER     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [CH*DW-1:0] s_data_i,
    input  logic [CH-1:0]    mute_i,
    output logic [CH-1:0]    pdm_o,
    output logic             cke_out_o,
    output logic             underrun_o
);
    localparam int unsigned DIVW = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
    localparam int unsigned AW   = DW + 4;
    localparam int unsigned XW   = DW + 6;
    localparam logic [DIVW-1:0]       DIV_LAST = DIVW'(DIV_RATIO - 1);
    localparam logic signed [XW-1:0]  FS       = XW'(64'd1 << (DW - 1));
    localparam logic signed [XW-1:0]  SAT_MAX  = XW'(64'd1 << (DW + 2));
    localparam logic signed [XW-1:0]  SAT_MIN  = -SAT_MAX;

    if ((ORDER != 1) && (ORDER != 2)) begin : g_order_chk
        $error("ds_dac_multi_ch: ORDER must be 1 or 2");
    end
    if ((CH < 1) || (CH > 8)) begin : g_ch_chk
        $error("ds_dac_multi_ch: CH must be 1..8");
    end

    // Clamp a wide sum into the integrator range instead of wrapping.
    function automatic logic signed [AW-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_MAX) begin
            return AW'(SAT_MAX);
        end
        if (v < SAT_MIN) begin
            return AW'(SAT_MIN);
        end
        return AW'(v);
    endfunction

    logic [DIVW-1:0]  div_q, div_d;
    logic             cke_q, cke_d;
    logic             ready_q, ready_d;
    logic             pending_q, pending_d;
    logic             underrun_q, underrun_d;
    logic [CH*DW-1:0] buf_q, buf_d;
    logic [CH*DW-1:0] cur_q, cur_d;
    logic [CH-1:0]    pdm_q, pdm_d;
    logic             xfer;

    // Divider, handshake and buffer->current hand-off.
    always_comb begin
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + DIVW'(1);
        cke_d      = (div_q == DIV_LAST);
        xfer       = s_valid_i & ready_q;
        buf_d      = xfer ? s_data_i : buf_q;
        cur_d      = cur_q;
        pending_d  = pending_q | xfer;
        underrun_d = 1'b0;
        if (cke_q) begin
            pending_d = xfer;
            if (pending_q) begin
                cur_d = buf_q;
            end else begin
                underrun_d = 1'b1;
            end
        end
        // ready_q always equals !pending_q | cke_q, but comes straight from a flop
        ready_d = ~pending_d | cke_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            cke_q      <= 1'b0;
            ready_q    <= 1'b1;
            pending_q  <= 1'b0;
            underrun_q <= 1'b0;
            buf_q      <= '0;
            cur_q      <= '0;
            pdm_q      <= '0;
        end else begin
            div_q      <= div_d;
            cke_q      <= cke_d;
            ready_q    <= ready_d;
            pending_q  <= pending_d;
            underrun_q <= underrun_d;
            buf_q      <= buf_d;
            cur_q      <= cur_d;
            if (cke_q) begin
                pdm_q <= pdm_d;
            end
        end
    end

`ifdef DS_DITHER_EN
    logic [15:0]       lfsr_q, lfsr_d;
    logic signed [1:0] dith;

    always_comb begin
        lfsr_d = lfsr_q;
        if (cke_q) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dith = lfsr_q[1:0];
`endif

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic signed [DW-1:0] smp;
        logic signed [XW-1:0] x, fb, s1, s2, q_in;
        logic signed [AW-1:0] a1_q, a1_d, a2_q, a2_d;

        assign smp = cur_q[k*DW +: DW];

        // CIFB modulator; the quantiser sees the updated last integrator.
        always_comb begin
            x = '0;
            if (!mute_i[k]) begin
                x = XW'(smp);
            end
            fb   = pdm_q[k] ? FS : -FS;
            s1   = XW'(a1_q) + x - fb;
            a1_d = sat(s1);
            s2   = XW'(a2_q) + XW'(a1_d) - fb;
            a2_d = '0;
            q_in = XW'(a1_d);
            if (ORDER == 2) begin
                a2_d = sat(s2);
                q_in = XW'(a2_d);
            end
`ifdef DS_DITHER_EN
            q_in = q_in + XW'(dith);
`endif
        end

        assign pdm_d[k] = ~q_in[XW-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                a1_q <= '0;
                a2_q <= '0;
            end else if (cke_q) begin
                a1_q <= a1_d;
                a2_q <= a2_d;
            end
        end
    end

    assign s_ready_o  = ready_q;
    assign pdm_o      = pdm_q;
    assign cke_out_o  = cke_q;
    assign underrun_o = underrun_q;

endmodule
